// File: rtl/rx_fifo_rr_scheduler.sv
// Round-robin read scheduler: shares one downstream serial-bit path among
// CH_NUM receive FIFOs, granting each channel bursts of up to BURST_LEN reads.
// Ports:
//   clk_100m, rst   : clock, asynchronous active-high reset
//   ch_en_i         : per-channel service enable
//   empty_i, full_i : FIFO status flags
//   dout_i          : FIFO read data, channel i at [4i+3:4i] (bit0 = data)
//   rd_en_o         : FIFO read enables (combinational, at most one high)
//   data_out        : {vld,2'b00,bit}, registered
//   ch_id_o         : channel of data_out / burst_end_o
//   burst_end_o     : one-cycle pulse closing a burst
//   busy_o          : scheduler not idle
//   ovf_flag_o      : sticky per-channel overflow flags
//   clr_ovf_i       : clears all overflow flags (a set in the same cycle wins)
module rx_fifo_rr_scheduler #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned BL_W      = 5
) (
    input  logic                  clk_100m,
    input  logic                  rst,
    input  logic [CH_NUM-1:0]     ch_en_i,
    input  logic [CH_NUM-1:0]     empty_i,
    input  logic [CH_NUM-1:0]     full_i,
    input  logic [4*CH_NUM-1:0]   dout_i,
    output logic [CH_NUM-1:0]     rd_en_o,
    output logic [3:0]            data_out,
    output logic [CH_W-1:0]       ch_id_o,
    output logic                  burst_end_o,
    output logic                  busy_o,
    output logic [CH_NUM-1:0]     ovf_flag_o,
    input  logic                  clr_ovf_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [BL_W-1:0]   cnt_q, cnt_d;
    logic              wait_q, wait_d;

    logic [CH_NUM-1:0] req;
    logic              pick_vld;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   cand;

    logic              rd_en_d1;
    logic [CH_W-1:0]   gnt_d1;

    // Only bit0 of each FIFO word carries data; the valid flag is regenerated.
    logic              dout_unused;
    assign dout_unused = ^dout_i;

    assign req = ch_en_i & ~empty_i;

    // Round-robin pick: first requester after the last grant, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= CH_NUM; k++) begin
            cand = CH_W'((32'(last_q) + k) % CH_NUM);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= CH_W'(CH_NUM - 1);
            cnt_q   <= '0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic and read enables.
    // wait_q marks that two drain cycles remain; an exit with no read in the
    // READ cycle has already spent one of them, so only one WAIT cycle follows.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        rd_en_o = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (ch_en_i[gnt_q] && !empty_i[gnt_q]) begin
                    rd_en_o[gnt_q] = 1'b1;
                    cnt_d          = cnt_q + BL_W'(1);
                    if (cnt_q == BL_W'(BURST_LEN - 1)) begin
                        state_d = S_WAIT;
                        wait_d  = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                    wait_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (wait_q) begin
                    wait_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output datapath: FIFO data arrives one cycle after rd_en, then is registered.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            rd_en_d1    <= 1'b0;
            gnt_d1      <= '0;
            data_out    <= '0;
            ch_id_o     <= '0;
            burst_end_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            rd_en_d1    <= |rd_en_o;
            gnt_d1      <= gnt_q;
            burst_end_o <= (state_d == S_DONE);
            busy_o      <= (state_d != S_IDLE);
            if (rd_en_d1) begin
                data_out <= {1'b1, 2'b00, dout_i[{gnt_d1, 2'b00}]};
                ch_id_o  <= gnt_d1;
            end else begin
                data_out <= '0;
                if (state_d == S_DONE) begin
                    ch_id_o <= gnt_q;
                end
            end
        end
    end

    // Sticky overflow flags.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            ovf_flag_o <= '0;
        end else begin
            ovf_flag_o <= (ovf_flag_o & ~{CH_NUM{clr_ovf_i}}) | full_i;
        end
    end

endmodule

// File: tb/tb_rx_fifo_rr_scheduler.sv
// Directed self-checking bench for rx_fifo_rr_scheduler with a behavioural
// FIFO model per channel (1-cycle read latency).
module tb_rx_fifo_rr_scheduler;

    localparam int unsigned CH_NUM    = 4;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned BURST_LEN = 16;
    localparam int unsigned BL_W      = 5;
    localparam int unsigned DEPTH     = 64;

    logic                clk_100m = 1'b0;
    logic                rst      = 1'b1;
    logic [CH_NUM-1:0]   ch_en_i  = '0;
    logic [CH_NUM-1:0]   empty_i;
    logic [CH_NUM-1:0]   full_i   = '0;
    logic [4*CH_NUM-1:0] dout_i;
    logic [CH_NUM-1:0]   rd_en_o;
    logic [3:0]          data_out;
    logic [CH_W-1:0]     ch_id_o;
    logic                burst_end_o;
    logic                busy_o;
    logic [CH_NUM-1:0]   ovf_flag_o;
    logic                clr_ovf_i = 1'b0;

    rx_fifo_rr_scheduler #(
        .CH_NUM(CH_NUM), .CH_W(CH_W), .BURST_LEN(BURST_LEN), .BL_W(BL_W)
    ) dut (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .ch_en_i    (ch_en_i),
        .empty_i    (empty_i),
        .full_i     (full_i),
        .dout_i     (dout_i),
        .rd_en_o    (rd_en_o),
        .data_out   (data_out),
        .ch_id_o    (ch_id_o),
        .burst_end_o(burst_end_o),
        .busy_o     (busy_o),
        .ovf_flag_o (ovf_flag_o),
        .clr_ovf_i  (clr_ovf_i)
    );

    always #5 clk_100m = ~clk_100m;

    // FIFO model: wp written by the stimulus, rp by the read process.
    bit         fifo_bit [CH_NUM][DEPTH];
    int         wp [CH_NUM] = '{default: 0};
    int         rp [CH_NUM] = '{default: 0};
    logic [3:0] dout_q [CH_NUM] = '{default: 4'h0};
    int         underflow_err = 0;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            empty_i[i]        = (wp[i] == rp[i]);
            dout_i[4*i +: 4]  = dout_q[i];
        end
    end

    always @(posedge clk_100m) begin
        for (int i = 0; i < CH_NUM; i++) begin
            if (rd_en_o[i]) begin
                if (wp[i] == rp[i]) begin
                    underflow_err = underflow_err + 1;
                end else begin
                    dout_q[i] <= {1'b1, 2'b00, fifo_bit[i][rp[i]]};
                    rp[i]     <= rp[i] + 1;
                end
            end
        end
    end

    // Output monitor: data scoreboard, one-hot rd_en, per-burst bookkeeping.
    int onehot_err = 0;
    int data_err   = 0;
    int vld_cnt    = 0;
    int burst_vld  = 0;
    int exp_idx [CH_NUM] = '{default: 0};
    int be_ch [$];
    int be_cnt [$];

    always @(negedge clk_100m) begin
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++) exp_idx[i] = rp[i];
            burst_vld = 0;
        end else begin
            if ($countones(rd_en_o) > 1) onehot_err = onehot_err + 1;
            if (data_out[3]) begin
                vld_cnt   = vld_cnt + 1;
                burst_vld = burst_vld + 1;
                if (data_out[2:0] !== {2'b00, fifo_bit[ch_id_o][exp_idx[ch_id_o]]})
                    data_err = data_err + 1;
                exp_idx[ch_id_o] = exp_idx[ch_id_o] + 1;
            end
            if (burst_end_o) begin
                be_ch.push_back(int'(ch_id_o));
                be_cnt.push_back(burst_vld);
                burst_vld = 0;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_100m);
    endtask

    task automatic push(input int ch, input bit b);
        fifo_bit[ch][wp[ch]] = b;
        wp[ch] = wp[ch] + 1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            next_cycle();
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_n  [8] = '{16, 16, 16, 16, 4, 4, 4, 4};

    initial begin
        int n0;
        int v0;
        int cyc;

        // Reset values
        sample();
        chk("rst_rd_en",     32'(rd_en_o),     32'd0);
        chk("rst_data_out",  32'(data_out),    32'd0);
        chk("rst_ch_id",     32'(ch_id_o),     32'd0);
        chk("rst_burst_end", 32'(burst_end_o), 32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_ovf",       32'(ovf_flag_o),  32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // All channels, 20 words each: two RR rounds, 16 then 4 reads
        n0 = be_ch.size();
        v0 = vld_cnt;
        for (int ch = 0; ch < CH_NUM; ch++)
            for (int k = 0; k < 20; k++)
                push(ch, bit'((k ^ (k >> 1) ^ ch) & 1));
        ch_en_i = 4'hF;
        cyc = 0;
        while (be_ch.size() < n0 + 8 && cyc < 600) begin
            next_cycle();
            cyc++;
        end
        chk("t2_bursts_done", 32'(be_ch.size() >= n0 + 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_burst_ch",  32'((be_ch.size() > n0 + i) ? be_ch[n0 + i] : -1),  32'(exp_ch[i]));
            chk("t2_burst_len", 32'((be_cnt.size() > n0 + i) ? be_cnt[n0 + i] : -1), 32'(exp_n[i]));
        end
        ch_en_i = 4'h0;
        next_cycle();
        wait_idle("t2_idle");
        chk("t2_valid_total", 32'(vld_cnt - v0), 32'd80);
        chk("t2_onehot",      32'(onehot_err),   32'd0);

        // Ch0 only, 3 words 1,0,1
        next_cycle();
        push(0, 1'b1);
        push(0, 1'b0);
        push(0, 1'b1);
        ch_en_i = 4'b0001;
        sample();
        chk("t1_idle_rd", 32'(rd_en_o), 32'd0);
        next_cycle(); sample();
        chk("t1_rd_c1",   32'(rd_en_o), 32'b0001);
        chk("t1_busy_c1", 32'(busy_o),  32'd1);
        next_cycle(); sample();
        chk("t1_rd_c2",   32'(rd_en_o), 32'b0001);
        next_cycle(); sample();
        chk("t1_rd_c3",   32'(rd_en_o),  32'b0001);
        chk("t1_data_c3", 32'(data_out), 32'b1001);
        chk("t1_id_c3",   32'(ch_id_o),  32'd0);
        next_cycle(); sample();
        chk("t1_rd_c4",   32'(rd_en_o),  32'd0);
        chk("t1_data_c4", 32'(data_out), 32'b1000);
        next_cycle(); sample();
        chk("t1_data_c5", 32'(data_out),    32'b1001);
        chk("t1_be_c5",   32'(burst_end_o), 32'd0);
        next_cycle(); sample();
        chk("t1_be_c6",   32'(burst_end_o), 32'd1);
        chk("t1_id_c6",   32'(ch_id_o),     32'd0);
        chk("t1_data_c6", 32'(data_out),    32'd0);
        next_cycle(); sample();
        chk("t1_busy_c7", 32'(busy_o),      32'd0);
        chk("t1_be_c7",   32'(burst_end_o), 32'd0);
        ch_en_i = 4'h0;

        // Ch2 disabled after 5 reads, ch3 waiting
        next_cycle();
        for (int k = 0; k < 10; k++) push(2, bit'(k & 1));
        push(3, 1'b1);
        push(3, 1'b0);
        ch_en_i = 4'b1100;
        sample();
        chk("t3_idle_rd", 32'(rd_en_o), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            next_cycle(); sample();
            chk("t3_rd_ch2", 32'(rd_en_o), 32'b0100);
        end
        next_cycle();
        ch_en_i = 4'b1000;
        sample();
        chk("t3_drop_rd", 32'(rd_en_o), 32'd0);
        next_cycle(); sample();
        chk("t3_be_early", 32'(burst_end_o), 32'd0);
        next_cycle(); sample();
        chk("t3_be",    32'(burst_end_o), 32'd1);
        chk("t3_be_id", 32'(ch_id_o),     32'd2);
        next_cycle(); sample();
        chk("t3_next_ch3",  32'(rd_en_o),                     32'b1000);
        chk("t3_burst_len", 32'(be_cnt[be_cnt.size() - 1]),   32'd5);
        chk("t3_burst_ch",  32'(be_ch[be_ch.size() - 1]),     32'd2);
        wait_idle("t3_idle");
        ch_en_i = 4'h0;

        // Wrap-around: last grant ch3, ch1+ch2 request -> ch1, then ch0
        next_cycle();
        push(1, 1'b1);
        push(1, 1'b1);
        ch_en_i = 4'b0110;
        sample();
        chk("t4_idle_rd", 32'(rd_en_o), 32'd0);
        next_cycle(); sample();
        chk("t4_wrap_ch1", 32'(rd_en_o), 32'b0010);
        next_cycle();
        next_cycle();
        push(0, 1'b0);
        ch_en_i = 4'b0001;
        next_cycle();
        next_cycle(); sample();
        chk("t4_be",    32'(burst_end_o), 32'd1);
        chk("t4_be_id", 32'(ch_id_o),     32'd1);
        next_cycle(); sample();
        chk("t4_next_ch0", 32'(rd_en_o), 32'b0001);
        wait_idle("t4_idle");
        ch_en_i = 4'h0;

        // Overflow flags: set, hold, clear, set wins over clear
        next_cycle();
        full_i = 4'b0100;
        sample();
        chk("t5_ovf_pre", 32'(ovf_flag_o), 32'd0);
        next_cycle();
        full_i = 4'b0000;
        sample();
        chk("t5_ovf_set", 32'(ovf_flag_o), 32'b0100);
        next_cycle(); sample();
        chk("t5_ovf_hold", 32'(ovf_flag_o), 32'b0100);
        next_cycle();
        clr_ovf_i = 1'b1;
        next_cycle();
        clr_ovf_i = 1'b0;
        sample();
        chk("t5_ovf_clr", 32'(ovf_flag_o), 32'd0);
        next_cycle();
        clr_ovf_i = 1'b1;
        full_i    = 4'b0100;
        next_cycle();
        clr_ovf_i = 1'b0;
        full_i    = 4'b0000;
        sample();
        chk("t5_ovf_set_wins", 32'(ovf_flag_o), 32'b0100);
        next_cycle();
        clr_ovf_i = 1'b1;
        next_cycle();
        clr_ovf_i = 1'b0;
        sample();
        chk("t5_ovf_clr2", 32'(ovf_flag_o), 32'd0);

        // Reset in the middle of a ch1 burst
        next_cycle();
        for (int k = 0; k < 10; k++) push(1, bit'((k >> 1) & 1));
        ch_en_i = 4'b0010;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle(); sample();
        chk("t6_rd_pre",    32'(rd_en_o),     32'b0010);
        chk("t6_vld_pre",   32'(data_out[3]), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rd",    32'(rd_en_o),     32'd0);
        chk("t6_rst_data",  32'(data_out),    32'd0);
        chk("t6_rst_busy",  32'(busy_o),      32'd0);
        chk("t6_rst_be",    32'(burst_end_o), 32'd0);
        next_cycle();
        push(0, 1'b1);
        push(0, 1'b0);
        ch_en_i = 4'b0011;
        next_cycle();
        rst = 1'b0;
        sample();
        chk("t6_idle_rd", 32'(rd_en_o), 32'd0);
        next_cycle(); sample();
        chk("t6_first_ch0", 32'(rd_en_o), 32'b0001);
        wait_idle("t6_idle");
        ch_en_i = 4'h0;

        chk("fin_ch0_drained", 32'(wp[0] - rp[0]), 32'd0);
        chk("fin_ch1_drained", 32'(wp[1] - rp[1]), 32'd0);
        chk("fin_data",        32'(data_err),      32'd0);
        chk("fin_onehot",      32'(onehot_err),    32'd0);
        chk("fin_underflow",   32'(underflow_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
